rect_matrix_mult: RTL

Parametrised successor of the square matrix multiplier. Computes C = A x B for runtime-selected rectangular shapes (ROWS x INNER times INNER x COLS, each up to MAX_DIM), with LANES parallel signed-integer multipliers. Sits between the control processor and register_file. Fetches A rows and B columns over the register-file handshake bus and writes complete C rows back.

---
 rtl/matmul_pkg.sv | 25 ++
 rtl/dot_product_mac.sv | 71 +++++++
 rtl/rect_matrix_mult.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// matmul_pkg: shared encodings for the rectangular matrix multiplier.
//   TYPE_*  : register-file access type placed on out_type
//   MAT_*   : matrix selector placed on out_matrix
//   state_t : controller FSM states (S_RD_C is only reachable when the
//             design is built with RECT_MATMUL_ACC_EN defined)
package matmul_pkg;

  localparam logic [1:0] TYPE_ROW = 2'b01;
  localparam logic [1:0] TYPE_COL = 2'b10;

  localparam logic [1:0] MAT_A = 2'b00;
  localparam logic [1:0] MAT_B = 2'b01;
  localparam logic [1:0] MAT_C = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_C,
    S_RD_B,
    S_MAC,
    S_WR_C,
    S_DONE
  } state_t;

endpackage

// File: rtl/dot_product_mac.sv
// dot_product_mac: LANES signed multipliers feeding an adder tree and a
// wide accumulator.
//   clk, rst   : clock, asynchronous active-high reset
//   clear      : load the accumulator with preload (start of a new cell)
//   enable     : add the sum of this cycle's valid lane products
//   preload    : starting value of the accumulator (0 or a sign-extended C cell)
//   a_lanes    : LANES operands, lane l at [l*CELL_WIDTH +: CELL_WIDTH]
//   b_lanes    : LANES operands, same layout
//   lane_valid : lanes with a 0 bit contribute nothing
//   acc_sum    : accumulator plus this cycle's lane total (combinational),
//                i.e. the value the accumulator takes when enable is high
module dot_product_mac #(
  parameter int CELL_WIDTH = 32,
  parameter int LANES      = 2,
  parameter int ACC_WIDTH  = 66
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        enable,
  input  logic [ACC_WIDTH-1:0]        preload,
  input  logic [LANES*CELL_WIDTH-1:0] a_lanes,
  input  logic [LANES*CELL_WIDTH-1:0] b_lanes,
  input  logic [LANES-1:0]            lane_valid,
  output logic [ACC_WIDTH-1:0]        acc_sum
);

  localparam int PROD_WIDTH = 2 * CELL_WIDTH;

  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] lane_total;
  logic [ACC_WIDTH-1:0] lane_ext [LANES];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [CELL_WIDTH-1:0]        a_l;
    logic [CELL_WIDTH-1:0]        b_l;
    logic signed [PROD_WIDTH-1:0] a_x;
    logic signed [PROD_WIDTH-1:0] b_x;
    logic signed [PROD_WIDTH-1:0] p_l;

    assign a_l = a_lanes[l*CELL_WIDTH +: CELL_WIDTH];
    assign b_l = b_lanes[l*CELL_WIDTH +: CELL_WIDTH];
    // Operands are widened explicitly so the multiply is full-width signed.
    assign a_x = {{CELL_WIDTH{a_l[CELL_WIDTH-1]}}, a_l};
    assign b_x = {{CELL_WIDTH{b_l[CELL_WIDTH-1]}}, b_l};
    assign p_l = a_x * b_x;
    assign lane_ext[l] = lane_valid[l]
                         ? {{(ACC_WIDTH-PROD_WIDTH){p_l[PROD_WIDTH-1]}}, p_l}
                         : '0;
  end

  always_comb begin
    lane_total = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_total = lane_total + lane_ext[l];
    end
  end

  assign acc_sum = acc_q + lane_total;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (clear) begin
      acc_q <= preload;
    end else if (enable) begin
      acc_q <= acc_sum;
    end
  end

endmodule

// File: rtl/rect_matrix_mult.sv
// rect_matrix_mult: computes C = A x B for runtime shapes
// (ROWS x INNER) * (INNER x COLS), each dimension up to MAX_DIM, fetching
// A rows and B columns from the register file and writing full C rows back.
//
// Build option: RECT_MATMUL_ACC_EN -- when defined, a start with
// in_accumulate high reads each C row first and computes C += A x B.
// When undefined, in_accumulate is ignored and C is overwritten.
//
// Ports:
//   in_clk, in_reset         clock, asynchronous active-high reset
//   in_ready                 start pulse (only looked at in IDLE)
//   in_rows/inner/cols       shape, latched on start
//   in_accumulate            accumulate request, latched on start
//   in_data, in_data_ready   register-file read data and completion strobe
//   out_ack                  host acknowledge of out_ready
//   out_reg_address          row access i*MAX_DIM, column access j
//   out_type, out_matrix     access type (01 row/10 col), matrix (A/B/C)
//   out_read_en/out_write_en request strobes
//   out_data                 C row being written, cell k at [k*CELL_WIDTH +: CELL_WIDTH]
//   out_ready, out_error     completion, shape-too-large flag
module rect_matrix_mult
  import matmul_pkg::*;
#(
  parameter int CELL_WIDTH    = 32,
  parameter int MAX_DIM       = 4,
  parameter int LANES         = 2,
  parameter int ADDRESS_WIDTH = $clog2(MAX_DIM*MAX_DIM),
  parameter int DIM_WIDTH     = $clog2(MAX_DIM+1)
) (
  input  logic                          in_clk,
  input  logic                          in_reset,
  input  logic                          in_ready,
  input  logic [DIM_WIDTH-1:0]          in_rows,
  input  logic [DIM_WIDTH-1:0]          in_inner,
  input  logic [DIM_WIDTH-1:0]          in_cols,
  input  logic                          in_accumulate,
  input  logic [MAX_DIM*CELL_WIDTH-1:0] in_data,
  input  logic                          in_data_ready,
  input  logic                          out_ack,
  output logic [ADDRESS_WIDTH-1:0]      out_reg_address,
  output logic [1:0]                    out_type,
  output logic [1:0]                    out_matrix,
  output logic                          out_read_en,
  output logic                          out_write_en,
  output logic [MAX_DIM*CELL_WIDTH-1:0] out_data,
  output logic                          out_ready,
  output logic                          out_error
);

  localparam int ACC_WIDTH = 2*CELL_WIDTH + $clog2(MAX_DIM);

  // Register-file handshake: a request is the enable (read or write) plus
  // address/type/matrix/out_data, all registered and held unchanged while
  // req_q is set. The request completes on the first clock edge that sees
  // in_data_ready high; read data is captured on that edge and the enable
  // drops, so at least one idle cycle precedes the next request.
  state_t                 state;
  logic                   req_q;
  logic [DIM_WIDTH-1:0]   rows_q, inner_q, cols_q;
  logic [DIM_WIDTH-1:0]   i_q, j_q, k_q;
  logic [CELL_WIDTH-1:0]  a_row [MAX_DIM];
  logic [CELL_WIDTH-1:0]  b_col [MAX_DIM];

  logic                        shape_big, shape_zero;
  logic                        mac_clear, mac_enable, mac_last;
  logic [ACC_WIDTH-1:0]        mac_preload, mac_sum;
  logic [LANES*CELL_WIDTH-1:0] a_lanes, b_lanes;
  logic [LANES-1:0]            lane_valid;
  logic [ADDRESS_WIDTH-1:0]    row_addr, col_addr;
  logic                        unused_mac_hi;

  assign shape_big  = (in_rows  > DIM_WIDTH'(MAX_DIM)) ||
                      (in_inner > DIM_WIDTH'(MAX_DIM)) ||
                      (in_cols  > DIM_WIDTH'(MAX_DIM));
  assign shape_zero = (in_rows == '0) || (in_inner == '0) || (in_cols == '0);

  assign row_addr = ADDRESS_WIDTH'(int'(i_q) * MAX_DIM);
  assign col_addr = ADDRESS_WIDTH'(j_q);

  assign mac_enable = (state == S_MAC);
  assign mac_clear  = (state == S_RD_B) && req_q && in_data_ready;
  assign mac_last   = (int'(k_q) + LANES) >= int'(inner_q);
  assign unused_mac_hi = ^mac_sum[ACC_WIDTH-1:CELL_WIDTH];

  // Route cells k_q .. k_q+LANES-1 to the lanes; lanes past INNER are masked.
  always_comb begin
    a_lanes    = '0;
    b_lanes    = '0;
    lane_valid = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int c = 0; c < MAX_DIM; c++) begin
        if (c == int'(k_q) + l) begin
          a_lanes[l*CELL_WIDTH +: CELL_WIDTH] = a_row[c];
          b_lanes[l*CELL_WIDTH +: CELL_WIDTH] = b_col[c];
        end
      end
      lane_valid[l] = (int'(k_q) + l) < int'(inner_q);
    end
  end

`ifdef RECT_MATMUL_ACC_EN
  logic                  acc_mode_q;
  logic [CELL_WIDTH-1:0] c_old [MAX_DIM];

  // Each output cell starts from the old C cell when accumulating.
  always_comb begin
    mac_preload = '0;
    if (acc_mode_q) begin
      for (int c = 0; c < MAX_DIM; c++) begin
        if (c == int'(j_q)) begin
          mac_preload = {{(ACC_WIDTH-CELL_WIDTH){c_old[c][CELL_WIDTH-1]}}, c_old[c]};
        end
      end
    end
  end
`else
  logic unused_accumulate;
  assign unused_accumulate = in_accumulate;
  assign mac_preload       = '0;
`endif

  dot_product_mac #(
    .CELL_WIDTH (CELL_WIDTH),
    .LANES      (LANES),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mac (
    .clk        (in_clk),
    .rst        (in_reset),
    .clear      (mac_clear),
    .enable     (mac_enable),
    .preload    (mac_preload),
    .a_lanes    (a_lanes),
    .b_lanes    (b_lanes),
    .lane_valid (lane_valid),
    .acc_sum    (mac_sum)
  );

  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      state           <= S_IDLE;
      req_q           <= 1'b0;
      rows_q          <= '0;
      inner_q         <= '0;
      cols_q          <= '0;
      i_q             <= '0;
      j_q             <= '0;
      k_q             <= '0;
      out_reg_address <= '0;
      out_type        <= '0;
      out_matrix      <= '0;
      out_read_en     <= 1'b0;
      out_write_en    <= 1'b0;
      out_data        <= '0;
      out_ready       <= 1'b0;
      out_error       <= 1'b0;
      for (int c = 0; c < MAX_DIM; c++) begin
        a_row[c] <= '0;
        b_col[c] <= '0;
      end
`ifdef RECT_MATMUL_ACC_EN
      acc_mode_q <= 1'b0;
      for (int c = 0; c < MAX_DIM; c++) c_old[c] <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_ready) begin
            rows_q  <= in_rows;
            inner_q <= in_inner;
            cols_q  <= in_cols;
            i_q     <= '0;
            j_q     <= '0;
`ifdef RECT_MATMUL_ACC_EN
            acc_mode_q <= in_accumulate;
`endif
            if (shape_big) begin
              out_error <= 1'b1;
              out_ready <= 1'b1;
              state     <= S_DONE;
            end else if (shape_zero) begin
              out_ready <= 1'b1;
              state     <= S_DONE;
            end else begin
              state <= S_RD_A;
            end
          end
        end

        S_RD_A: begin
          if (!req_q) begin
            req_q           <= 1'b1;
            out_read_en     <= 1'b1;
            out_reg_address <= row_addr;
            out_type        <= TYPE_ROW;
            out_matrix      <= MAT_A;
            out_data        <= '0;  // fresh C row: cells past COLS stay 0
          end else if (in_data_ready) begin
            req_q       <= 1'b0;
            out_read_en <= 1'b0;
            for (int c = 0; c < MAX_DIM; c++) a_row[c] <= in_data[c*CELL_WIDTH +: CELL_WIDTH];
            j_q <= '0;
`ifdef RECT_MATMUL_ACC_EN
            state <= acc_mode_q ? S_RD_C : S_RD_B;
`else
            state <= S_RD_B;
`endif
          end
        end

`ifdef RECT_MATMUL_ACC_EN
        S_RD_C: begin
          if (!req_q) begin
            req_q           <= 1'b1;
            out_read_en     <= 1'b1;
            out_reg_address <= row_addr;
            out_type        <= TYPE_ROW;
            out_matrix      <= MAT_C;
          end else if (in_data_ready) begin
            req_q       <= 1'b0;
            out_read_en <= 1'b0;
            for (int c = 0; c < MAX_DIM; c++) c_old[c] <= in_data[c*CELL_WIDTH +: CELL_WIDTH];
            state <= S_RD_B;
          end
        end
`endif

        S_RD_B: begin
          if (!req_q) begin
            req_q           <= 1'b1;
            out_read_en     <= 1'b1;
            out_reg_address <= col_addr;
            out_type        <= TYPE_COL;
            out_matrix      <= MAT_B;
          end else if (in_data_ready) begin
            req_q       <= 1'b0;
            out_read_en <= 1'b0;
            for (int c = 0; c < MAX_DIM; c++) b_col[c] <= in_data[c*CELL_WIDTH +: CELL_WIDTH];
            k_q   <= '0;
            state <= S_MAC;
          end
        end

        S_MAC: begin
          k_q <= k_q + DIM_WIDTH'(LANES);
          if (mac_last) begin
            // Store the final sum directly; low bits only (wraparound).
            for (int c = 0; c < MAX_DIM; c++) begin
              if (c == int'(j_q)) out_data[c*CELL_WIDTH +: CELL_WIDTH] <= mac_sum[CELL_WIDTH-1:0];
            end
            if ((j_q + DIM_WIDTH'(1)) < cols_q) begin
              j_q   <= j_q + DIM_WIDTH'(1);
              state <= S_RD_B;
            end else begin
              state <= S_WR_C;
            end
          end
        end

        S_WR_C: begin
          if (!req_q) begin
            req_q           <= 1'b1;
            out_write_en    <= 1'b1;
            out_reg_address <= row_addr;
            out_type        <= TYPE_ROW;
            out_matrix      <= MAT_C;
          end else if (in_data_ready) begin
            req_q        <= 1'b0;
            out_write_en <= 1'b0;
            if ((i_q + DIM_WIDTH'(1)) < rows_q) begin
              i_q   <= i_q + DIM_WIDTH'(1);
              state <= S_RD_A;
            end else begin
              out_ready <= 1'b1;
              state     <= S_DONE;
            end
          end
        end

        S_DONE: begin
          if (out_ack) begin
            out_ready <= 1'b0;
            out_error <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
